mem_stage_sram_ctrl: RTL and testbench
======================================

// Module: mem_stage_sram_ctrl
// PURPOSE
//   MEM-stage data-memory access unit, directly downstream of the EXE stage.
//   Takes the EXE ALU result as the byte address and the forwarded Rm value as store data.
//   Performs 32-bit loads/stores on an external 16-bit SRAM as two half-word accesses (low, then high).
//   Drives ready low while an access is in flight; the hazard/freeze logic stalls IF/ID/EXE on ~ready.
// PARAMETERS
//   BASE_ADDR   32'd1024  first data-memory byte address; subtracted before SRAM mapping
//   WAIT_CYCLES 2         cycles each half-word access is held on the SRAM bus (>=1)
//   ADDR_W      18        SRAM half-word address width
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous, active-high reset
//   mem_r_en     in   1       load request from EXE/MEM pipeline register
//   mem_w_en     in   1       store request from EXE/MEM pipeline register
//   alu_res      in   32      byte address; bits [1:0] ignored (word aligned)
//   val_Rm       in   32      store data
//   mem_rdata    out  32      load result; valid in DONE, held until the next load completes
//   ready        out  1       1 = MEM stage may advance; 0 = freeze upstream stages
//   sram_addr    out  ADDR_W  half-word address
//   sram_dq_out  out  16      write data to SRAM
//   sram_dq_oe   out  1       1 = drive sram_dq_out onto the bus (stores only)
//   sram_dq_in   in   16      read data from SRAM
//   sram_we_n    out  1       active-low write strobe
// BEHAVIOUR
//   Reset: state=IDLE, mem_rdata=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, wait counter=0.
//   Reset mid-access aborts immediately; no partial write completes after rst rises.
//   FSM states: IDLE -> LO -> HI -> DONE -> IDLE.
//   IDLE: on (mem_r_en|mem_w_en), latch addr, wdata and op (write if mem_w_en, else read), go to LO.
//     Both enables high is treated as a write.
//   LO: sram_addr={word,1'b0}; hold WAIT_CYCLES cycles; on the last cycle, a read captures sram_dq_in into rdata[15:0].
//   HI: sram_addr={word,1'b1}; hold WAIT_CYCLES cycles; on the last cycle, a read captures into rdata[31:16].
//   DONE: one cycle; ready=1; mem_rdata updated (reads only); next state IDLE.
//   Address mapping: word = (addr - BASE_ADDR) >> 2, truncated to ADDR_W-1 bits (wraps modulo SRAM size).
//   Writes: in LO/HI, sram_we_n=0 and sram_dq_oe=1.
//     sram_dq_out = wdata[15:0] in LO, wdata[31:16] in HI.
//   Reads: in LO/HI, sram_we_n=1 and sram_dq_oe=0.
//   ready (combinational):
//     1 in IDLE with no request; 0 in IDLE with a request; 0 in LO/HI; 1 in DONE.
//   Latency: request first seen in cycle 0 -> ready=1 in cycle 2*WAIT_CYCLES+1 (5 at default).
//   Handshake: upstream holds requests stable while ready=0.
//     A request present in the cycle after DONE starts a new access (back-to-back allowed).
//   Requests arriving in LO/HI/DONE are not sampled until IDLE.
//   In IDLE without a request: sram_we_n=1, sram_dq_oe=0; sram_addr holds its last value.
// TESTING
//   1 Idle: mem_r_en=mem_w_en=0 for 10 cycles -> ready=1 throughout, sram_we_n=1, sram_dq_oe=0.
//   2 Store: alu_res=1028, val_Rm=32'hDEADBEEF ->
//     sram_addr=2 with dq=16'hBEEF and we_n=0 for 2 cycles;
//     then sram_addr=3 with dq=16'hDEAD for 2 cycles;
//     ready=1 in cycle 5.
//   3 Load: SRAM model holds [2]=16'hBEEF, [3]=16'hDEAD; load alu_res=1028 ->
//     ready low in cycles 0-4; mem_rdata=32'hDEADBEEF at cycle 5.
//   4 Back-to-back: store 1024<-32'h12345678, then load 1024 in the next cycle ->
//     second ready pulse at cycle 11; mem_rdata=32'h12345678.
//   5 Reset mid-store: assert rst during HI ->
//     same cycle: we_n=1, oe=0, ready=1, mem_rdata=0;
//     SRAM address 3 unchanged.
//   6 WAIT_CYCLES=1 plus both enables high with alu_res=1032 ->
//     treated as a store to sram_addr 4 then 5; ready at cycle 3.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side request/response signals and the 16-bit SRAM bus of the MEM-stage
// data-memory unit, bundled so the controller and its environment share one port.
interface mem_stage_sram_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic              mem_r_en;
    logic              mem_w_en;
    logic [31:0]       alu_res;
    logic [31:0]       val_Rm;
    logic [31:0]       mem_rdata;
    logic              ready;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_out;
    logic              sram_dq_oe;
    logic [15:0]       sram_dq_in;
    logic              sram_we_n;

    // master: pipeline plus SRAM device (the controller's environment)
    modport master (
        output mem_r_en, mem_w_en, alu_res, val_Rm, sram_dq_in,
        input  mem_rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  mem_r_en, mem_w_en, alu_res, val_Rm, sram_dq_in,
        output mem_rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: one 32-bit load/store becomes two 16-bit SRAM
// accesses (low half then high half); ready stays low while the access is in flight.
module mem_stage_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2,
    parameter int          ADDR_W      = 18
) (
    input  logic clk,
    input  logic rst,
    mem_stage_sram_ctrl_if.slave bus
);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t              state_reg,       state_next;
    logic [CNT_W-1:0]    wait_cnt_reg,    wait_cnt_next;
    logic [ADDR_W-2:0]   word_reg,        word_next;
    logic [31:0]         wdata_reg,       wdata_next;
    logic                write_reg,       write_next;
    logic [15:0]         rdata_lo_reg,    rdata_lo_next;
    logic [31:0]         mem_rdata_reg,   mem_rdata_next;
    logic [ADDR_W-1:0]   sram_addr_reg,   sram_addr_next;
    logic [15:0]         sram_dq_out_reg, sram_dq_out_next;
    logic                sram_dq_oe_reg,  sram_dq_oe_next;
    logic                sram_we_n_reg,   sram_we_n_next;
    logic                ready;

    logic [31:0]       offset;
    logic [ADDR_W-2:0] word_in;
    logic              request;
    logic              unused_bits;

    // Word index wraps modulo the SRAM size; the byte-lane bits are ignored.
    assign offset      = bus.alu_res - BASE_ADDR;
    assign word_in     = offset[ADDR_W:2];
    assign unused_bits = ^{offset[31:ADDR_W+1], offset[1:0]};
    assign request     = bus.mem_r_en | bus.mem_w_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            wait_cnt_reg    <= '0;
            word_reg        <= '0;
            wdata_reg       <= '0;
            write_reg       <= 1'b0;
            rdata_lo_reg    <= '0;
            mem_rdata_reg   <= '0;
            sram_addr_reg   <= '0;
            sram_dq_out_reg <= '0;
            sram_dq_oe_reg  <= 1'b0;
            sram_we_n_reg   <= 1'b1;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            word_reg        <= word_next;
            wdata_reg       <= wdata_next;
            write_reg       <= write_next;
            rdata_lo_reg    <= rdata_lo_next;
            mem_rdata_reg   <= mem_rdata_next;
            sram_addr_reg   <= sram_addr_next;
            sram_dq_out_reg <= sram_dq_out_next;
            sram_dq_oe_reg  <= sram_dq_oe_next;
            sram_we_n_reg   <= sram_we_n_next;
        end
    end

    // Bus outputs are registered from the next state, so they are already valid
    // in the first cycle of LO/HI and drop the moment rst rises.
    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        word_next        = word_reg;
        wdata_next       = wdata_reg;
        write_next       = write_reg;
        rdata_lo_next    = rdata_lo_reg;
        mem_rdata_next   = mem_rdata_reg;
        sram_addr_next   = sram_addr_reg;
        sram_dq_out_next = sram_dq_out_reg;
        sram_dq_oe_next  = 1'b0;
        sram_we_n_next   = 1'b1;
        ready            = 1'b0;

        case (state_reg)
            IDLE: begin
                ready = ~request;
                if (request) begin
                    word_next        = word_in;
                    wdata_next       = bus.val_Rm;
                    write_next       = bus.mem_w_en;
                    wait_cnt_next    = '0;
                    state_next       = LO;
                    sram_addr_next   = {word_in, 1'b0};
                    sram_dq_out_next = bus.val_Rm[15:0];
                    sram_dq_oe_next  = bus.mem_w_en;
                    sram_we_n_next   = ~bus.mem_w_en;
                end
            end
            LO: begin
                sram_dq_oe_next = write_reg;
                sram_we_n_next  = ~write_reg;
                if (wait_cnt_reg == WAIT_LAST) begin
                    if (!write_reg) begin
                        rdata_lo_next = bus.sram_dq_in;
                    end
                    wait_cnt_next    = '0;
                    state_next       = HI;
                    sram_addr_next   = {word_reg, 1'b1};
                    sram_dq_out_next = wdata_reg[31:16];
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            HI: begin
                sram_dq_oe_next = write_reg;
                sram_we_n_next  = ~write_reg;
                if (wait_cnt_reg == WAIT_LAST) begin
                    if (!write_reg) begin
                        mem_rdata_next = {bus.sram_dq_in, rdata_lo_reg};
                    end
                    wait_cnt_next   = '0;
                    state_next      = DONE;
                    sram_dq_oe_next = 1'b0;
                    sram_we_n_next  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ready       = ready;
    assign bus.mem_rdata   = mem_rdata_reg;
    assign bus.sram_addr   = sram_addr_reg;
    assign bus.sram_dq_out = sram_dq_out_reg;
    assign bus.sram_dq_oe  = sram_dq_oe_reg;
    assign bus.sram_we_n   = sram_we_n_reg;
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed loads/stores against a behavioural SRAM,
// a phase-based reference model checked every cycle, and hand-computed literals.
module tb_mem_stage_sram_ctrl;
    localparam int W = 2;

    logic clk;
    logic rst;
    logic init_mem;
    int   n_checks;
    int   n_err;
    int   cyc;

    mem_stage_sram_ctrl_if #(.ADDR_W(18)) bus0 ();
    mem_stage_sram_ctrl_if #(.ADDR_W(18)) bus1 ();

    mem_stage_sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2), .ADDR_W(18)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    mem_stage_sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1), .ADDR_W(18)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    // Behavioural SRAMs: combinational read, write at clock edge while strobed.
    logic [15:0] dev0 [256];
    logic [15:0] dev1 [256];
    assign bus0.sram_dq_in = dev0[bus0.sram_addr[7:0]];
    assign bus1.sram_dq_in = dev1[bus1.sram_addr[7:0]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) dev0[i] <= 16'h0;
        end else if (!bus0.sram_we_n && bus0.sram_dq_oe) begin
            dev0[bus0.sram_addr[7:0]] <= bus0.sram_dq_out;
        end
    end
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) dev1[i] <= 16'h0;
        end else if (!bus1.sram_we_n && bus1.sram_dq_oe) begin
            dev1[bus1.sram_addr[7:0]] <= bus1.sram_dq_out;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an access accepted in cycle 0 drives the low half-word in
    // cycles 1..W, the high half-word in W+1..2W and reports done in 2W+1.
    logic [15:0] ref_mem [256];
    initial begin
        int          m_busy, m_phase, m_word, m_last_addr, a, half;
        logic        m_wr;
        logic [31:0] m_wd, m_rdata, tmp;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
        m_busy = 0; m_phase = 0; m_word = 0; m_last_addr = 0;
        m_wr = 1'b0; m_wd = '0; m_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 0; m_rdata = '0; m_last_addr = 0;
                chk("m_rst_we_n", bus0.sram_we_n, 1);
                chk("m_rst_oe", bus0.sram_dq_oe, 0);
                chk("m_rst_addr", bus0.sram_addr, 0);
                chk("m_rst_rdata", bus0.mem_rdata, 0);
                chk("m_rst_ready", bus0.ready, !(bus0.mem_r_en || bus0.mem_w_en));
            end else if (m_busy == 0) begin
                chk("m_idle_ready", bus0.ready, !(bus0.mem_r_en || bus0.mem_w_en));
                chk("m_idle_we_n", bus0.sram_we_n, 1);
                chk("m_idle_oe", bus0.sram_dq_oe, 0);
                chk("m_idle_addr", bus0.sram_addr, m_last_addr);
                chk("m_idle_rdata", bus0.mem_rdata, m_rdata);
                if (bus0.mem_r_en || bus0.mem_w_en) begin
                    m_busy  = 1;
                    m_phase = 0;
                    m_wr    = bus0.mem_w_en;
                    m_wd    = bus0.val_Rm;
                    tmp     = bus0.alu_res - 32'd1024;
                    m_word  = int'((tmp >> 2) % 32'd131072);
                end
            end else begin
                m_phase++;
                if (m_phase <= 2 * W) begin
                    half = (m_phase > W) ? 1 : 0;
                    a    = m_word * 2 + half;
                    chk("m_busy_ready", bus0.ready, 0);
                    chk("m_busy_addr", bus0.sram_addr, a);
                    chk("m_busy_we_n", bus0.sram_we_n, !m_wr);
                    chk("m_busy_oe", bus0.sram_dq_oe, m_wr);
                    chk("m_busy_rdata", bus0.mem_rdata, m_rdata);
                    if (m_wr) begin
                        chk("m_busy_dq", bus0.sram_dq_out, half ? m_wd[31:16] : m_wd[15:0]);
                        if (m_phase == W) ref_mem[a & 255] = m_wd[15:0];
                        if (m_phase == 2 * W) ref_mem[a & 255] = m_wd[31:16];
                    end
                end else begin
                    if (!m_wr) m_rdata = {ref_mem[(m_word * 2 + 1) & 255], ref_mem[(m_word * 2) & 255]};
                    m_last_addr = m_word * 2 + 1;
                    chk("m_done_ready", bus0.ready, 1);
                    chk("m_done_rdata", bus0.mem_rdata, m_rdata);
                    chk("m_done_we_n", bus0.sram_we_n, 1);
                    chk("m_done_oe", bus0.sram_dq_oe, 0);
                    chk("m_done_addr", bus0.sram_addr, m_last_addr);
                    m_busy = 0;
                end
            end
        end
    end

    // Per-cycle trace of the latest access on dut0, index = cycle since request.
    logic        tr_ready [32];
    logic [17:0] tr_addr  [32];
    logic [15:0] tr_dq    [32];
    logic        tr_we_n  [32];

    // Starts an access just after a rising edge and returns just after the edge
    // that ends the done cycle; enables are left for the caller to change.
    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, output int rdy_cyc);
        bus0.mem_w_en = wr;
        bus0.mem_r_en = rd;
        bus0.alu_res  = a;
        bus0.val_Rm   = d;
        rdy_cyc = -1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            tr_ready[k] = bus0.ready;
            tr_addr[k]  = bus0.sram_addr;
            tr_dq[k]    = bus0.sram_dq_out;
            tr_we_n[k]  = bus0.sram_we_n;
            if (k > 0 && bus0.ready) begin
                rdy_cyc = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("access_completes", rdy_cyc >= 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        bus0.mem_w_en = 1'b0;
        bus0.mem_r_en = 1'b0;
    endtask

    initial begin
        int rc, t0;
        n_checks = 0; n_err = 0; cyc = 0;
        rst = 1'b1; init_mem = 1'b1;
        bus0.mem_r_en = 0; bus0.mem_w_en = 0; bus0.alu_res = '0; bus0.val_Rm = '0;
        bus1.mem_r_en = 0; bus1.mem_w_en = 0; bus1.alu_res = '0; bus1.val_Rm = '0;
        repeat (3) @(posedge clk);
        #1;
        init_mem = 1'b0;
        chk("rst_ready", bus0.ready, 1);
        chk("rst_we_n", bus0.sram_we_n, 1);
        chk("rst_oe", bus0.sram_dq_oe, 0);
        chk("rst_addr", bus0.sram_addr, 0);
        chk("rst_rdata", bus0.mem_rdata, 0);
        rst = 1'b0;

        // 1: idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", bus0.ready, 1);
            chk("idle_we_n", bus0.sram_we_n, 1);
            chk("idle_oe", bus0.sram_dq_oe, 0);
        end
        @(posedge clk);
        #1;

        // 2: store DEADBEEF to 1028
        access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, rc);
        go_idle();
        $display("store 1028 <- deadbeef: ready at cycle %0d", rc);
        chk("st_ready_cyc", rc, 5);
        chk("st_c0_ready", tr_ready[0], 0);
        chk("st_c1_addr", tr_addr[1], 2);
        chk("st_c1_dq", tr_dq[1], 16'hBEEF);
        chk("st_c2_we_n", tr_we_n[2], 0);
        chk("st_c3_addr", tr_addr[3], 3);
        chk("st_c4_dq", tr_dq[4], 16'hDEAD);
        chk("st_c4_we_n", tr_we_n[4], 0);
        chk("st_mem2", dev0[2], 16'hBEEF);
        chk("st_mem3", dev0[3], 16'hDEAD);

        // 3: load 1028
        repeat (2) begin @(posedge clk); #1; end
        access(1'b0, 1'b1, 32'd1028, 32'h0, rc);
        go_idle();
        $display("load 1028: ready at cycle %0d data %08h", rc, bus0.mem_rdata);
        chk("ld_ready_cyc", rc, 5);
        chk("ld_c0_ready", tr_ready[0], 0);
        chk("ld_c4_ready", tr_ready[4], 0);
        chk("ld_c1_we_n", tr_we_n[1], 1);
        chk("ld_rdata", bus0.mem_rdata, 32'hDEADBEEF);

        // 4: back-to-back store then load at 1024
        @(posedge clk);
        #1;
        t0 = cyc;
        access(1'b1, 1'b0, 32'd1024, 32'h12345678, rc);
        access(1'b0, 1'b1, 32'd1024, 32'h0, rc);
        go_idle();
        $display("b2b store/load 1024: second ready at cycle %0d data %08h", cyc - 1 - t0, bus0.mem_rdata);
        chk("b2b_ready_cyc", cyc - 1 - t0, 11);
        chk("b2b_rdata", bus0.mem_rdata, 32'h12345678);
        chk("b2b_mem0", dev0[0], 16'h5678);
        chk("b2b_mem1", dev0[1], 16'h1234);

        // 5: reset in the middle of the high half of a store
        @(posedge clk);
        #1;
        bus0.mem_w_en = 1'b1; bus0.alu_res = 32'd1028; bus0.val_Rm = 32'hCAFEF00D;
        repeat (3) begin @(posedge clk); #1; end
        chk("rs_pre_addr", bus0.sram_addr, 3);
        chk("rs_pre_we_n", bus0.sram_we_n, 0);
        rst = 1'b1;
        go_idle();
        #1;
        $display("reset during store HI: we_n=%0b oe=%0b ready=%0b rdata=%08h",
                 bus0.sram_we_n, bus0.sram_dq_oe, bus0.ready, bus0.mem_rdata);
        chk("rs_we_n", bus0.sram_we_n, 1);
        chk("rs_oe", bus0.sram_dq_oe, 0);
        chk("rs_ready", bus0.ready, 1);
        chk("rs_rdata", bus0.mem_rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rs_mem3_kept", dev0[3], 16'hDEAD);
        chk("rs_mem2_lo", dev0[2], 16'hF00D);

        // 6: single-wait-cycle instance, both enables high
        begin
            int          r1;
            logic [17:0] a1 [8];
            logic [15:0] d1 [8];
            logic        w1 [8];
            logic        y1 [8];
            r1 = -1;
            bus1.mem_w_en = 1'b1; bus1.mem_r_en = 1'b1;
            bus1.alu_res = 32'd1032; bus1.val_Rm = 32'hA5A55A5A;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                a1[k] = bus1.sram_addr; d1[k] = bus1.sram_dq_out;
                w1[k] = bus1.sram_we_n; y1[k] = bus1.ready;
                if (k > 0 && bus1.ready) begin
                    r1 = k;
                    break;
                end
                @(posedge clk);
                #1;
            end
            @(posedge clk);
            #1;
            bus1.mem_w_en = 1'b0; bus1.mem_r_en = 1'b0;
            $display("W=1 r+w 1032 <- a5a55a5a: ready at cycle %0d", r1);
            chk("w1_ready_cyc", r1, 3);
            chk("w1_c0_ready", y1[0], 0);
            chk("w1_c1_addr", a1[1], 4);
            chk("w1_c1_dq", d1[1], 16'h5A5A);
            chk("w1_c1_we_n", w1[1], 0);
            chk("w1_c2_addr", a1[2], 5);
            chk("w1_c2_dq", d1[2], 16'hA5A5);
            chk("w1_c2_we_n", w1[2], 0);
            chk("w1_mem4", dev1[4], 16'h5A5A);
            chk("w1_mem5", dev1[5], 16'hA5A5);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
